bsg_murn_gather: RTL and testbench

- Collects the per-node block-to-switch streams (valid/yumi, one per murn node) and merges them into a single valid/ready channel toward bsg_comm_link.
- Round-robin arbitrates among nodes and prepends the source node id to each word.
- Registers the merged word in a one-entry output stage that sustains full throughput.
- Sits directly downstream of the murn converter's per-node two-element FIFOs.

---
 rtl/bsg_murn_gather.sv | 120 ++++++++++++
 tb/tb_bsg_murn_gather.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bsg_murn_gather.sv
// Round-robin gather of per-node murn streams into one registered valid/ready channel.
// Optional BSG_MURN_GATHER_LOCK_EN: payload MSB marks a continuation and locks the arbiter.
module bsg_murn_gather #(
  parameter  int nodes_p      = 4,
  parameter  int ring_width_p = 8,
  localparam int id_width_lp  = (nodes_p > 1) ? $clog2(nodes_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [nodes_p-1:0]                  v_i,
  input  logic [nodes_p*ring_width_p-1:0]     data_i,
  output logic [nodes_p-1:0]                  yumi_o,
  output logic                                v_o,
  output logic [id_width_lp+ring_width_p-1:0] data_o,
  input  logic                                ready_i,
  output logic [id_width_lp-1:0]              last_id_o
);

  logic                                v_q, v_d;
  logic [id_width_lp+ring_width_p-1:0] data_q, data_d;
  logic [id_width_lp-1:0]              last_id_q, last_id_d;
`ifdef BSG_MURN_GATHER_LOCK_EN
  logic                                lock_q, lock_d;
`endif

  logic                    accept;
  logic                    grant_found;
  logic [id_width_lp-1:0]  grant_id;
  logic [ring_width_p-1:0] grant_word;
  int                      idx;

  assign accept = ~v_q | ready_i;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = last_id_q;
    idx         = 0;
`ifdef BSG_MURN_GATHER_LOCK_EN
    if (lock_q) begin
      // a locked packet owner is always the node granted last
      grant_found = v_i[last_id_q];
      grant_id    = last_id_q;
    end else begin
`endif
      for (int i = 1; i <= nodes_p; i++) begin
        idx = int'(last_id_q) + i;
        if (idx >= nodes_p) begin
          idx = idx - nodes_p;
        end else begin
          idx = idx;
        end
        if (!grant_found && v_i[idx]) begin
          grant_found = 1'b1;
          grant_id    = id_width_lp'(idx);
        end else begin
          grant_found = grant_found;
        end
      end
`ifdef BSG_MURN_GATHER_LOCK_EN
    end
`endif
  end

  assign grant_word = data_i[int'(grant_id)*ring_width_p +: ring_width_p];

  always_comb begin
    yumi_o = '0;
    if (accept && grant_found && !reset_i) begin
      yumi_o[grant_id] = 1'b1;
    end else begin
      yumi_o = '0;
    end
  end

  always_comb begin
    v_d       = v_q;
    data_d    = data_q;
    last_id_d = last_id_q;
`ifdef BSG_MURN_GATHER_LOCK_EN
    lock_d    = lock_q;
`endif
    if (accept) begin
      v_d = grant_found;
      if (grant_found) begin
        data_d    = {grant_id, grant_word};
        last_id_d = grant_id;
`ifdef BSG_MURN_GATHER_LOCK_EN
        lock_d    = grant_word[ring_width_p-1];
`endif
      end else begin
        data_d = data_q;
      end
    end else begin
      v_d = v_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q       <= 1'b0;
      data_q    <= '0;
      last_id_q <= id_width_lp'(nodes_p - 1);
`ifdef BSG_MURN_GATHER_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      v_q       <= v_d;
      data_q    <= data_d;
      last_id_q <= last_id_d;
`ifdef BSG_MURN_GATHER_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  assign v_o       = v_q;
  assign data_o    = data_q;
  assign last_id_o = last_id_q;

endmodule

// File: tb/tb_bsg_murn_gather.sv
// Randomized bench for bsg_murn_gather (nodes_p=4, ring_width_p=8) against a per-word
// round-robin reference; honours BSG_MURN_GATHER_LOCK_EN when defined.
module tb_bsg_murn_gather;

  localparam int N = 4;
  localparam int W = 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N-1:0]      v_i;
  logic [N*W-1:0]    data_i;
  logic [N-1:0]      yumi_o;
  logic              v_o;
  logic [2+W-1:0]    data_o;
  logic              ready_i;
  logic [1:0]        last_id_o;

  bsg_murn_gather #(.nodes_p(N), .ring_width_p(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .v_o(v_o), .data_o(data_o), .ready_i(ready_i), .last_id_o(last_id_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // reference state: what the link currently holds and who was served last
  logic        m_v;
  logic [9:0]  m_data;
  int          m_last;
  logic        m_locked;
  int          m_grant;   // node dequeued in the most recent cycle, -1 if none

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic rdy, input bit chk);
    logic [N-1:0] exp_yumi;
    logic [W-1:0] word;
    bit acc, found;
    int g;
    @(negedge clk_i);
    reset_i = rst; v_i = v; data_i = d; ready_i = rdy;
    #1;
    acc = !m_v || rdy;
    found = 0; g = 0;
    if (m_locked) begin
      found = v[m_last]; g = m_last;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!found && v[(m_last + k) % N]) begin
          found = 1; g = (m_last + k) % N;
        end
      end
    end
    exp_yumi = (acc && found && !rst) ? (4'b0001 << g) : 4'b0000;
    if (chk) begin
      check_value("yumi_o", 32'(yumi_o), 32'(exp_yumi));
      check_value("v_o", 32'(v_o), 32'(m_v));
      if (m_v) check_value("data_o", 32'(data_o), 32'(m_data));
      check_value("last_id_o", 32'(last_id_o), 32'(m_last));
    end
    m_grant = (exp_yumi != 4'b0000) ? g : -1;
    word = d[g*W +: W];
    if (rst) begin
      m_v = 0; m_data = '0; m_last = N - 1; m_locked = 0;
    end else if (acc) begin
      m_v = found;
      if (found) begin
        m_data = {2'(g), word};
        m_last = g;
`ifdef BSG_MURN_GATHER_LOCK_EN
        m_locked = word[W-1];
`endif
      end
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    return {$urandom, $urandom} & {N*W{1'b1}};
  endfunction

  logic [N*W-1:0] d;
  logic [W-1:0]   seq [3];
  int             n1;

  initial begin
    reset_i = 1'b1; v_i = '0; data_i = '0; ready_i = 1'b0;
    m_v = 0; m_data = '0; m_last = N - 1; m_locked = 0; m_grant = -1;
    cycle(1'b1, 4'b0000, '0, 1'b0, 0);
    cycle(1'b1, 4'b0000, '0, 1'b0, 1);
    cycle(1'b1, 4'b1111, rand_data(), 1'b1, 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, rand_data(), 1'(i % 2), 1);

    // all nodes valid at full rate: node 0 first, then strict rotation
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 4'b1111, rand_data(), 1'b1, 1);
      if (i < 5) check_value("rr_order", 32'(m_grant), 32'(i % N));
    end
    // stall with a held word, then release without a bubble
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, rand_data(), 1'b0, 1);
    cycle(1'b0, 4'b1111, rand_data(), 1'b1, 1);
    cycle(1'b0, 4'b1111, rand_data(), 1'b1, 1);

    // single requester node 2
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0100, rand_data(), 1'b1, 1);
      check_value("single_req", 32'(m_grant), 32'd2);
    end

    // reset while a word is held and the link is stalled
    cycle(1'b0, 4'b1111, rand_data(), 1'b0, 1);
    cycle(1'b1, 4'b1111, rand_data(), 1'b0, 1);
    cycle(1'b0, 4'b1111, rand_data(), 1'b1, 1);
    check_value("first_after_reset", 32'(m_grant), 32'd0);
    cycle(1'b0, 4'b0000, rand_data(), 1'b1, 1);

    // node 1 sends a three-word packet (MSB 1,1,0) while node 3 competes
    cycle(1'b1, 4'b0000, '0, 1'b1, 1);
    seq[0] = 8'h81; seq[1] = 8'h92; seq[2] = 8'h23;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      d = rand_data();
      d[1*W +: W] = seq[(n1 < 3) ? n1 : 2];
      cycle(1'b0, (n1 < 3) ? 4'b1010 : 4'b1000, d, 1'b1, 1);
      if (m_grant == 1) n1++;
    end

    // random traffic, backpressure and occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 4'($urandom), rand_data(),
            ($urandom_range(0, 9) < 7), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
